// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch-buffer entry type.
package rv32i_pkg;

    localparam int unsigned      XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer; clear has priority over push/pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push     = push_i & ~clear_i;
    assign w_pop      = pop_i & ~clear_i & ~empty_o;
    assign full_o     = (r_count == (AW+1)'(DEPTH));
    assign empty_o    = (r_count == '0);
    assign count_o    = r_count;
    assign pop_data_o = r_mem[r_rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clear_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= push_data_i;
    end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: credit-limited in-order fetch, response
// buffering, redirect flush with drop counting, and the IF/ID register.
module if_stage
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [XLEN-1:0]  imem_rdata_i,
    output logic [XLEN-1:0]  instruction_o,
    output logic [XLEN-1:0]  pc_address_o,
    output logic             if_valid_o
);

    localparam int unsigned  CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]  DEPTH_L = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;

    logic [CW-1:0]   w_fifo_count;
    logic [CW-1:0]   w_outstanding_nxt;
    logic [CW:0]     w_inflight;
    logic [XLEN-1:0] w_target;
    logic            w_grant;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Credits cover both buffered and in-flight words, so the FIFO cannot overflow.
    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign imem_req_o  = rst_ni & (w_inflight < DEPTH_L) & ~redirect_i;
    assign imem_addr_o = r_fetch_pc;
    assign w_grant     = imem_req_o & imem_gnt_i;
    assign w_target    = redirect_pc_i & ~XLEN'(3);

    assign w_push       = imem_rvalid_i & ~redirect_i & (r_drop_cnt == '0);
    assign w_pop        = ~redirect_i & ~stall_i & ~w_fifo_empty;
    assign w_push_entry = '{pc: r_resp_pc, instr: imem_rdata_i};

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        unique case ({w_grant, imem_rvalid_i})
            2'b10:   w_outstanding_nxt = r_outstanding + CW'(1);
            2'b01:   w_outstanding_nxt = r_outstanding - CW'(1);
            default: w_outstanding_nxt = r_outstanding;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (redirect_i) begin
                // Everything still in flight after this edge belongs to the old path.
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_drop_cnt <= w_outstanding_nxt;
            end else begin
                if (w_grant) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (imem_rvalid_i) begin
                    if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CW'(1);
                    else                  r_resp_pc  <= r_resp_pc + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSN;
            r_pc    <= '0;
        end else if (redirect_i) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSN;
            r_pc    <= '0;
        end else if (!stall_i) begin
            if (!w_fifo_empty) begin
                r_valid <= 1'b1;
                r_instr <= w_head.instr;
                r_pc    <= w_head.pc;
            end else begin
                r_valid <= 1'b0;
                r_instr <= NOP_INSN;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*XLEN)
    ) u_fetch_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (redirect_i),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (w_fifo_count)
    );

    assign instruction_o = r_instr;
    assign pc_address_o  = r_pc;
    assign if_valid_o    = r_valid;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && w_fifo_full));

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage with a configurable grant-delay/latency memory model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        req;
    logic [31:0] addr;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        valid;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned mq_due[$];
    logic [31:0] mq_addr[$];
    int unsigned cyc = 0;
    int unsigned gnt_delay = 0;
    int unsigned lat = 1;
    int unsigned wait_cnt = 0;
    int unsigned last_due = 0;
    int unsigned mem_due;
    logic [31:0] held_addr = '0;
    exp_t        got;
    int          n_vec = 0;
    int          n_err = 0;

    if_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .instruction_o (insn),
        .pc_address_o  (pc),
        .if_valid_o    (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0010_0093;
            32'h4:   return 32'h0020_0113;
            32'h8:   return 32'h0030_0193;
            default: return 32'hA500_0013 ^ (a << 8);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++)
            exp_q.push_back('{pc: start + 32'(4*i), insn: word_at(start + 32'(4*i))});
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] target, input int n);
        redirect_pc = target;
        redirect    = 1'b1;
        start_stream(target & ~32'h3, n);
        #1;
        check("rd_cycle_req", {31'd0, req}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("rd_valid_clr", {31'd0, valid}, 32'd0);
        check("rd_next_req", {31'd0, req}, 32'd1);
        check("rd_next_addr", addr, target & ~32'h3);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: grants after gnt_delay held cycles, answers lat cycles after grant, in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq_due.delete();
            mq_addr.delete();
            gnt      = 1'b0;
            rvalid   = 1'b0;
            wait_cnt = 0;
            last_due = 0;
        end else begin
            rvalid = 1'b0;
            if (mq_due.size() != 0 && mq_due[0] == cyc) begin
                rvalid = 1'b1;
                rdata  = word_at(mq_addr[0]);
                void'(mq_due.pop_front());
                void'(mq_addr.pop_front());
            end
            gnt = 1'b0;
            if (req) begin
                if (wait_cnt == 0) held_addr = addr;
                else               check("addr_hold", addr, held_addr);
                if (wait_cnt >= gnt_delay) begin
                    gnt     = 1'b1;
                    mem_due = cyc + lat;
                    if (mem_due <= last_due) mem_due = last_due + 1;
                    last_due = mem_due;
                    mq_due.push_back(mem_due);
                    mq_addr.push_back(addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ID side consumes one instruction per unstalled valid cycle.
    always @(negedge clk) begin
        if (rst_n && !redirect && !stall && valid && exp_q.size() != 0) begin
            got = exp_q.pop_front();
            check("sb_pc", pc, got.pc);
            check("sb_insn", insn, got.insn);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_insn", insn, 32'h0000_0013);
        check("rst_pc", pc, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);

        // Release before edge 0; zero-wait memory.
        start_stream(32'h0, 40);
        rst_n = 1'b1;
        tick();
        check("e0_valid", {31'd0, valid}, 32'd0);
        check("e0_addr", addr, 32'h4);
        tick();
        check("e1_valid", {31'd0, valid}, 32'd0);
        tick();
        check("e2_valid", {31'd0, valid}, 32'd1);
        check("e2_pc", pc, 32'h0);
        check("e2_insn", insn, 32'h0010_0093);
        tick();
        check("e3_pc", pc, 32'h4);
        check("e3_insn", insn, 32'h0020_0113);
        tick();
        check("e4_pc", pc, 32'h8);
        check("e4_insn", insn, 32'h0030_0193);
        tick();

        // Five-cycle stall: register holds the next expected entry.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            if (exp_q.size() == 0) check("stall_sb", 32'd0, 32'd1);
            else begin
                check("stall_pc", pc, exp_q[0].pc);
                check("stall_insn", insn, exp_q[0].insn);
                check("stall_valid", {31'd0, valid}, 32'd1);
            end
        end
        check("stall_credit_req", {31'd0, req}, 32'd0);
        stall = 1'b0;
        wait_drain(100);

        // Redirect with several requests in flight.
        lat = 3;
        repeat (6) tick();
        do_redirect(32'h0000_0103, 10);
        wait_drain(150);

        // Redirect while responses and grants stream every cycle.
        lat = 2;
        repeat (6) tick();
        do_redirect(32'h0000_0200, 8);
        wait_drain(100);

        // Slow grant: address must stay put until accepted.
        gnt_delay = 3;
        lat = 1;
        do_redirect(32'h0000_0300, 8);
        wait_drain(200);

        // Mid-stream reset with the buffer full.
        gnt_delay = 0;
        do_redirect(32'h0000_0400, 4);
        wait_drain(50);
        stall = 1'b1;
        repeat (8) tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mrst_insn", insn, 32'h0000_0013);
        check("mrst_pc", pc, 32'd0);
        check("mrst_valid", {31'd0, valid}, 32'd0);
        check("mrst_req", {31'd0, req}, 32'd0);
        stall = 1'b0;
        repeat (2) tick();
        start_stream(32'h0, 6);
        rst_n = 1'b1;
        #1;
        check("mrst_first_req", {31'd0, req}, 32'd1);
        check("mrst_first_addr", addr, 32'h0);
        wait_drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
